// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs symbolic instructions into MIPS words
// and writes them sequentially into instruction memory, one word per two cycles.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [3:0]               mnem_i,
  input  logic [4:0]               rs_i,
  input  logic [4:0]               rt_i,
  input  logic [4:0]               rd_i,
  input  logic [15:0]              imm_i,
  input  logic                     last_i,
  output logic                     imem_we_o,
  output logic [31:0]              imem_addr_o,
  output logic [31:0]              imem_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     done_o,
  output logic                     full_o,
  output logic                     err_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_last;
  logic          r_err;
  logic          r_full;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;

  logic          w_legal;
  logic [31:0]   w_word;
  logic [CW-1:0] w_count_nx;
  logic [31:0]   w_wr_addr;

  always_comb begin
    w_legal = 1'b1;
    w_word  = '0;
    case (mnem_i)
      4'd0:    w_word = {6'd0, rs_i, rt_i, rd_i, 5'd0, 6'h20};
      4'd1:    w_word = {6'd0, rs_i, rt_i, rd_i, 5'd0, 6'h22};
      4'd2:    w_word = {6'd0, rs_i, rt_i, rd_i, 5'd0, 6'h24};
      4'd3:    w_word = {6'd0, rs_i, rt_i, rd_i, 5'd0, 6'h25};
      4'd4:    w_word = {6'd0, rs_i, rt_i, rd_i, 5'd0, 6'h2A};
      4'd5:    w_word = {6'h08, rs_i, rt_i, imm_i};
      4'd6:    w_word = {6'h04, rs_i, rt_i, imm_i};
      4'd7:    w_word = {6'h0D, rs_i, rt_i, imm_i};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_count_nx = r_count + CW'(1);
  assign w_wr_addr  = BASE_ADDR + 32'({r_count, 2'b00});

  // Address and data are captured at acceptance so they are stable during WRITE
  // and hold afterwards without a separate hold path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_err   <= 1'b0;
            r_full  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid_i) begin
            if (w_legal) begin
              r_data  <= w_word;
              r_addr  <= w_wr_addr;
              r_last  <= last_i;
              r_state <= S_WRITE;
            end else begin
              r_err <= 1'b1;
              if (last_i) r_state <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          r_count <= w_count_nx;
          if (w_count_nx == DEPTH_C) r_full <= 1'b1;
          r_state <= (r_last || (w_count_nx == DEPTH_C)) ? S_DONE : S_LOAD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == S_LOAD);
  assign imem_we_o   = (r_state == S_WRITE);
  assign done_o      = (r_state == S_DONE);
  assign imem_addr_o = r_addr;
  assign imem_data_o = r_data;
  assign count_o     = r_count;
  assign full_o      = r_full;
  assign err_o       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized sessions
// checked against a queue-based write model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, start_i = 1'b0, in_valid_i = 1'b0, last_i = 1'b0;
  logic [3:0]  mnem_i = '0;
  logic [4:0]  rs_i = '0, rt_i = '0, rd_i = '0;
  logic [15:0] imm_i = '0;

  logic        ready, we, done, full, err;
  logic [31:0] addr, data;
  logic [5:0]  count;
  logic        ready4, we4, done4, full4, err4;
  logic [31:0] addr4, data4;
  logic [2:0]  count4;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [63:0] exp_q[$];
  logic [63:0] q4[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  int          exp_n = 0, exp_n4 = 0, w4_cnt = 0;
  bit          exp_err = 0;
  bit          mon_main = 1, mon4 = 0;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(ready), .mnem_i(mnem_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .imm_i(imm_i), .last_i(last_i), .imem_we_o(we), .imem_addr_o(addr),
    .imem_data_o(data), .count_o(count), .done_o(done), .full_o(full), .err_o(err)
  );

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .in_valid_i(in_valid_i),
    .in_ready_o(ready4), .mnem_i(mnem_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
    .imm_i(imm_i), .last_i(last_i), .imem_we_o(we4), .imem_addr_o(addr4),
    .imem_data_o(data4), .count_o(count4), .done_o(done4), .full_o(full4), .err_o(err4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoding from the opcode/funct tables; bit 32 flags a legal mnemonic.
  function automatic logic [32:0] model_enc(input int m, input int s, input int t,
                                            input int d, input int im);
    int unsigned fn[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
    int unsigned op[3] = '{32'h08, 32'h04, 32'h0D};
    int unsigned w;
    if (m < 5) begin
      w = s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + fn[m];
      return {1'b1, 32'(w)};
    end else if (m < 8) begin
      w = op[m-5] * (1 << 26) + s * (1 << 21) + t * (1 << 16) + im;
      return {1'b1, 32'(w)};
    end
    return {1'b0, 32'h0};
  endfunction

  always @(negedge clk) begin
    if (mon_main && we) begin
      logic [63:0] e;
      n_assert++;
      log_addr.push_back(addr);
      log_data.push_back(data);
      log_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", addr, data);
      end else begin
        e = exp_q.pop_front();
        if ({addr, data} !== e) begin
          n_fail++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   addr, data, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon4 && we4) begin
      logic [63:0] e;
      n_assert++;
      w4_cnt++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write4: got addr=%h data=%h, required no write", addr4, data4);
      end else begin
        e = q4.pop_front();
        if ({addr4, data4} !== e) begin
          n_fail++;
          $display("FAIL write4: got addr=%h data=%h, required addr=%h data=%h",
                   addr4, data4, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete(); q4.delete();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    exp_n = 0; exp_n4 = 0; exp_err = 0; w4_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; last_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    clear_model();
  endtask

  task automatic start_session();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    clear_model();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (valid left high).
  task automatic send_beat(input bit use4, input int m, input int s, input int t,
                           input int d, input int im, input bit lst, output bit acc);
    logic [32:0] r;
    mnem_i = 4'(m); rs_i = 5'(s); rt_i = 5'(t); rd_i = 5'(d); imm_i = 16'(im);
    last_i = lst; in_valid_i = 1'b1; acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((use4 ? ready4 : ready) === 1'b1) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (acc) begin
      r = model_enc(m, s, t, d, im);
      if (r[32]) begin
        if (use4) begin q4.push_back({32'(4 * exp_n4), r[31:0]}); exp_n4++; end
        else      begin exp_q.push_back({32'(4 * exp_n), r[31:0]}); exp_n++; end
      end else begin
        exp_err = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input bit use4);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if ((use4 ? done4 : done) === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    n_assert++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: got done=0, required done=1 within 20 cycles");
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++;
    if ({ready, we, addr, data, count, done, full, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h cnt=%0d dn=%b fl=%b er=%b, required all 0",
               ready, we, addr, data, count, done, full, err);
    end
    n_assert++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: got %b required 0", ready);
    end
  endtask

  task automatic test_single();
    bit acc;
    do_reset();
    start_session();
    n_assert++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b required 1", ready); end
    send_beat(0, 0, 1, 2, 3, 16'h5555, 1, acc);
    in_valid_i = 1'b0;
    wait_done(0);
    n_assert++;
    if (log_data.size() != 1 || log_data[0] !== 32'h00221820 || log_addr[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL single_word: got n=%0d word=%h, required n=1 word=00221820 addr=0",
               log_data.size(), (log_data.size() > 0) ? log_data[0] : 32'hx);
    end
    n_assert++;
    if (count !== 6'd1 || done !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status: got cnt=%0d dn=%b fl=%b, required cnt=1 dn=1 fl=0", count, done, full);
    end
  endtask

  task automatic test_sequence();
    bit acc;
    logic [31:0] wexp[4] = '{32'h20010005, 32'h3422FFFF, 32'h1022FFFF, 32'h0022202A};
    do_reset();
    start_session();
    send_beat(0, 5, 0, 1, 7, 5, 0, acc);
    send_beat(0, 7, 1, 2, 0, 16'hFFFF, 0, acc);
    send_beat(0, 6, 1, 2, 0, 16'hFFFF, 0, acc);
    send_beat(0, 4, 1, 2, 4, 16'h1234, 1, acc);
    in_valid_i = 1'b0;
    wait_done(0);
    for (int i = 0; i < 4; i++) begin
      n_assert++;
      if (i >= log_data.size() || log_data[i] !== wexp[i] || log_addr[i] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL seq_word%0d: got word=%h addr=%h, required word=%h addr=%h", i,
                 (i < log_data.size()) ? log_data[i] : 32'hx,
                 (i < log_addr.size()) ? log_addr[i] : 32'hx, wexp[i], 32'(4 * i));
      end
    end
    for (int i = 1; i < 4; i++) begin
      n_assert++;
      if (i >= log_cyc.size() || log_cyc[i] - log_cyc[i-1] != 2) begin
        n_fail++;
        $display("FAIL seq_spacing%0d: got gap=%0d, required 2", i,
                 (i < log_cyc.size()) ? log_cyc[i] - log_cyc[i-1] : -1);
      end
    end
    n_assert++;
    if (count !== 6'd4 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_count: got cnt=%0d fl=%b, required cnt=4 fl=0", count, full);
    end
  endtask

  task automatic test_illegal();
    bit acc;
    do_reset();
    start_session();
    send_beat(0, 0, 1, 2, 3, 0, 0, acc);
    send_beat(0, 9, 7, 7, 7, 16'hABCD, 0, acc);
    n_assert++;
    if (err !== 1'b1 || ready !== 1'b1 || we !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_beat: got err=%b rdy=%b we=%b, required err=1 rdy=1 we=0", err, ready, we);
    end
    send_beat(0, 1, 4, 5, 6, 0, 1, acc);
    in_valid_i = 1'b0;
    wait_done(0);
    n_assert++;
    if (log_data.size() != 2 || log_data[1] !== 32'h00853022 || log_addr[1] !== 32'h4) begin
      n_fail++;
      $display("FAIL illegal_gap: got n=%0d, required 2 writes, second word 00853022 at 4", log_data.size());
    end
    n_assert++;
    if (err !== 1'b1 || count !== 6'd2) begin
      n_fail++;
      $display("FAIL illegal_sticky: got err=%b cnt=%0d, required err=1 cnt=2", err, count);
    end
  endtask

  task automatic test_full();
    bit acc;
    mon_main = 0; mon4 = 1;
    do_reset();
    start_session();
    for (int i = 0; i < 6; i++) begin
      send_beat(1, 0, i, i + 1, i + 2, 0, 0, acc);
      n_assert++;
      if (acc !== (i < 4)) begin
        n_fail++;
        $display("FAIL full_accept%0d: got accepted=%b, required %b", i, acc, (i < 4));
      end
    end
    in_valid_i = 1'b0;
    n_assert++;
    if (w4_cnt != 4 || full4 !== 1'b1 || done4 !== 1'b1 || ready4 !== 1'b0 || count4 !== 3'd4) begin
      n_fail++;
      $display("FAIL full_status: got writes=%0d fl=%b dn=%b rdy=%b cnt=%0d, required 4 1 1 0 4",
               w4_cnt, full4, done4, ready4, count4);
    end
    mon4 = 0;
    do_reset();
    mon_main = 1;
  endtask

  task automatic test_reset_mid_write();
    bit acc;
    do_reset();
    start_session();
    send_beat(0, 2, 3, 4, 5, 0, 0, acc);
    n_assert++;
    if (we !== 1'b1) begin n_fail++; $display("FAIL pre_reset_we: got %b required 1", we); end
    rst_i = 1'b1; in_valid_i = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({ready, we, addr, data, count, done, full, err} !== '0) begin
      n_fail++;
      $display("FAIL mid_write_reset: got rdy=%b we=%b a=%h d=%h cnt=%0d, required all 0",
               ready, we, addr, data, count);
    end
    rst_i = 1'b0;
    start_session();
    send_beat(0, 7, 1, 2, 0, 16'h1234, 1, acc);
    in_valid_i = 1'b0;
    wait_done(0);
    n_assert++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h0 || log_data[0] !== 32'h34221234) begin
      n_fail++;
      $display("FAIL restart_addr: got n=%0d, required one write of 34221234 at 0", log_addr.size());
    end
  endtask

  task automatic test_start_ignored();
    bit acc;
    do_reset();
    start_session();
    send_beat(0, 9, 0, 0, 0, 0, 0, acc);
    send_beat(0, 3, 1, 2, 3, 0, 0, acc);
    start_i = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b0;
    n_assert++;
    if (count !== 6'd1 || ready !== 1'b1 || done !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_load: got cnt=%0d rdy=%b dn=%b err=%b, required 1 1 0 1", count, ready, done, err);
    end
    send_beat(0, 2, 5, 6, 7, 0, 1, acc);
    in_valid_i = 1'b0;
    wait_done(0);
    n_assert++;
    if (log_addr.size() != 2 || log_addr[1] !== 32'h4 || count !== 6'd2) begin
      n_fail++;
      $display("FAIL start_ignored_addr: got n=%0d cnt=%0d, required 2 writes, cnt=2", log_addr.size(), count);
    end
    start_session();
    n_assert++;
    if (count !== 6'd0 || done !== 1'b0 || err !== 1'b0 || full !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_done: got cnt=%0d dn=%b err=%b fl=%b rdy=%b, required 0 0 0 0 1",
               count, done, err, full, ready);
    end
    send_beat(0, 5, 9, 10, 0, 16'h8000, 1, acc);
    in_valid_i = 1'b0;
    wait_done(0);
    n_assert++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL done_restart_addr: got n=%0d, required one write at 0", log_addr.size());
    end
  endtask

  task automatic test_random();
    bit acc;
    int nb, gap;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      start_session();
      nb = $urandom_range(1, 10);
      for (int b = 0; b < nb; b++) begin
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          in_valid_i = 1'b0;
          repeat (gap) @(negedge clk);
        end
        send_beat(0, $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 65535), (b == nb - 1), acc);
        n_assert++;
        if (!acc) begin
          n_fail++;
          $display("FAIL rand_accept s%0d b%0d: got accepted=0, required 1", s, b);
        end
      end
      in_valid_i = 1'b0;
      wait_done(0);
      n_assert++;
      if (count !== 6'(exp_n) || err !== exp_err || full !== 1'b0 || exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL rand_session%0d: got cnt=%0d err=%b fl=%b pending=%0d, required cnt=%0d err=%b fl=0 pending=0",
                 s, count, err, full, exp_q.size(), exp_n, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_illegal();
    test_full();
    test_reset_mid_write();
    test_start_ignored();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
